// File: rtl/smem_bank_arbiter.sv
// One shared-memory bank: round-robin arbitration over the core load/store ports,
// bank storage, and a registered one-cycle finish/data response to the granted core.
module smem_bank_arbiter #(
    parameter int NUM_CORES = 16,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int BANK_ID   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        read,
    input  logic [NUM_CORES-1:0]        write,
    input  logic [NUM_CORES*ADDR_W-1:0] addr_in,
    input  logic [NUM_CORES*DATA_W-1:0] data_in,
    output logic [NUM_CORES*DATA_W-1:0] data_out,
    output logic [NUM_CORES-1:0]        finish,
    output logic                        busy,
    output logic [3:0]                  grant_id,
    output logic [1:0]                  fsm_state
);

    // Handshake: a core raises read/write (level) with stable addr/data and holds
    // them until it samples finish[k]=1; it drops them at that same clock edge.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int         WORD_W   = ADDR_W - 4;
    localparam int         DEPTH    = 1 << WORD_W;
    localparam logic [3:0] BANK_SEL = 4'(BANK_ID);

    state_t state, state_next;

    logic [NUM_CORES-1:0] eligible;
    logic                 any_elig;
    logic [3:0]           winner;
    logic [3:0]           cand;
    logic [WORD_W-1:0]    win_word;
    logic [DATA_W-1:0]    win_data;
    logic                 win_write;

    logic [3:0]           rr;
    logic [3:0]           grant_q;
    logic                 op_write;
    logic [WORD_W-1:0]    word_q;
    logic [DATA_W-1:0]    wdata_q;

    logic [DATA_W-1:0]    mem [DEPTH];

    logic [NUM_CORES-1:0]        finish_d;
    logic [NUM_CORES*DATA_W-1:0] data_out_d;
    logic                        busy_d;

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            eligible[k] = (read[k] | write[k]) && (addr_in[k*ADDR_W +: 4] == BANK_SEL);
        end
    end

    // First eligible core in the order rr, rr+1, ... wrapping at NUM_CORES.
    always_comb begin
        any_elig = 1'b0;
        winner   = '0;
        cand     = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = 4'((int'(rr) + i) % NUM_CORES);
            if (!any_elig && eligible[cand]) begin
                any_elig = 1'b1;
                winner   = cand;
            end
        end
    end

    always_comb begin
        win_word  = addr_in[int'(winner)*ADDR_W + 4 +: WORD_W];
        win_data  = data_in[int'(winner)*DATA_W +: DATA_W];
        win_write = write[winner];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_elig) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A read+write request is treated as a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr       <= '0;
            grant_q  <= '0;
            op_write <= 1'b0;
            word_q   <= '0;
            wdata_q  <= '0;
        end else if (state == IDLE && any_elig) begin
            rr       <= (winner == 4'(NUM_CORES - 1)) ? 4'd0 : winner + 4'd1;
            grant_q  <= winner;
            op_write <= win_write;
            word_q   <= win_word;
            wdata_q  <= win_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == ACCESS && op_write) begin
            mem[word_q] <= wdata_q;
        end
    end

    always_comb begin
        finish_d   = '0;
        data_out_d = '0;
        busy_d     = (state_next != IDLE);
        if (state == ACCESS) begin
            finish_d[grant_q] = 1'b1;
            if (!op_write) begin
                data_out_d[int'(grant_q)*DATA_W +: DATA_W] = mem[word_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            finish   <= '0;
            data_out <= '0;
            busy     <= 1'b0;
        end else begin
            finish   <= finish_d;
            data_out <= data_out_d;
            busy     <= busy_d;
        end
    end

    assign grant_id  = grant_q;
    assign fsm_state = state;

endmodule

// File: doc/smem_bank_arbiter.md
# smem_bank_arbiter

Round-robin access controller for one bank of the GPU shared memory. It owns the bank storage and the arbitration between the 16 gpu_core load/store ports. It selects one pending request that targets its bank, performs the read or write, and returns a one-cycle `finish` pulse with the read data to the winning core. The GPU top instantiates one per bank and ORs the `data_out`/`finish` buses of all banks.

## Interface
- `NUM_CORES`, 16, number of requesting cores.
- `ADDR_W`, 12, per-core address width. Bank select is `addr[3:0]`; word index is `addr[11:4]`, giving 256 words per bank.
- `DATA_W`, 8, word width.
- `BANK_ID`, 0, bank number this instance serves (0..15).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `read` in NUM_CORES: per-core load request level.
- `write` in NUM_CORES: per-core store request level.
- `addr_in` in NUM_CORES*ADDR_W: core k address at `[12k+11:12k]`.
- `data_in` in NUM_CORES*DATA_W: core k store data at `[8k+7:8k]`.
- `data_out` out NUM_CORES*DATA_W: core k load data slice. Non-zero only during that core's response cycle.
- `finish` out NUM_CORES: one-cycle completion pulse per core.
- `busy` out 1: high in ACCESS and RESP.
- `grant_id` out 4: index of the current or last granted core (debug).

## Operation
- Core k is eligible when `(read[k] | write[k]) & (addr_in[k][3:0] == BANK_ID)`.
- Requests are levels. A core holds `read`/`write`, `addr` and `data` stable until it samples `finish[k]=1`, then deasserts them at that same edge.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any core is eligible, latch winner index, op, word index and store data; go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: write op stores data at the edge ending ACCESS. Read op loads the word into the response register at the same edge. Go to RESP.
  - RESP: `finish[g]=1`. For a read, `data_out[g]` = read word. For a write, `data_out` = 0. Go to IDLE.
- Round-robin rule:
  - Pointer `rr` starts at 0.
  - The search order is `rr, rr+1, ... rr+15` (mod 16). The first eligible core wins.
  - After a grant, `rr = winner+1` (mod 16; 15 wraps to 0).
- If `read[k]` and `write[k]` are both set, the operation is a write. It completes with `finish` and `data_out[k]=0`.
- Requests targeting other banks are ignored entirely.
- Bank storage is not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: state IDLE, `rr`=0, `finish`=0, `data_out`=0, `busy`=0, `grant_id`=0.
- Reset has priority in every state. Reset asserted during ACCESS aborts the op: no write occurs and no `finish` is issued.
- Latency:
  - Request visible in IDLE at cycle 0.
  - ACCESS in cycle 1.
  - `finish` and data in cycle 2.
  - Earliest next grant decision in cycle 3 (IDLE).
- Throughput: one access per 3 cycles per bank. Banks operate independently.
- A request arriving during ACCESS or RESP waits for the next IDLE.
- The grantee's request is already low in the IDLE cycle after RESP, by the handshake rule. There is no re-grant of a stale request.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Single write then read. Core 3 writes 0xA5 to addr 0x125 on BANK_ID=5.
  - Required: `finish[3]` pulses in cycle 2.
  - Core 3 then reads 0x125. Required: `finish[3]=1` with `data_out[31:24]=0xA5` in cycle 2 of the read.
- Round-robin fairness. Cores 0, 7 and 15 all read bank 0 simultaneously from reset (`rr`=0).
  - Required grant order: 0, 7, 15.
  - Required `finish` pulses: cycles 2, 5 and 8.
- Wrap-around. After a grant to 15, cores 2 and 14 request.
  - Required: core 2 is granted first, since `rr` wrapped to 0.
- Bank filtering. Core 1 requests addr 0x013 on the BANK_ID=2 instance.
  - Required: no `finish`, `busy` stays 0, for 10 cycles.
- Read/write both set. Core 4 asserts `read=1` and `write=1` with data 0x3C.
  - Required: write performed and `data_out[39:32]=0` during RESP.
  - A subsequent read returns 0x3C.
- Reset mid-op. Assert `reset` during the ACCESS cycle of a write of 0x77 to a word previously holding 0x11.
  - Required: no `finish` pulse, and all outputs are zero after reset.
  - A later read returns 0x11.
